// File: rtl/carry_lookahead_adder_bist.sv
// carry_lookahead_adder_bist -- exhaustive-sweep self-test controller for carry_lookahead_adder
// Rev 1.0
`default_nettype none

module carry_lookahead_adder_bist #(
   parameter int WIDTH          = 3,
   parameter int NUM_ITERATIONS = 10,
   parameter int CNT_W          = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_inject_err,
   output logic [WIDTH-1:0]   o_add1,
   output logic [WIDTH-1:0]   o_add2,
   input  logic [WIDTH:0]     i_result,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [CNT_W-1:0]   o_error_cnt,
   output logic [WIDTH-1:0]   o_fail_add1,
   output logic [WIDTH-1:0]   o_fail_add2,
   output logic [WIDTH:0]     o_fail_result
);

   localparam int ITER_W = (NUM_ITERATIONS > 1) ? $clog2(NUM_ITERATIONS) : 1;
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITERATIONS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [ITER_W-1:0]   iter;
   logic                fail_seen;

   logic [WIDTH:0]      sum_ref;
   logic [WIDTH:0]      expected;
   logic                inject_hit;
   logic                mismatch;
   logic [CNT_W-1:0]    cnt_next;
   logic                last_vec;

   // Reference sum and injected corruption; only used while in CHECK
   always_comb begin
      sum_ref    = {1'b0, o_add1} + {1'b0, o_add2};
      inject_hit = i_inject_err && (iter != '0) && (&o_add1);
      expected   = inject_hit ? ~sum_ref : sum_ref;
      mismatch   = (i_result != expected);
      cnt_next   = (mismatch && (o_error_cnt != '1)) ? o_error_cnt + CNT_W'(1) : o_error_cnt;
      last_vec   = (&o_add1) && (&o_add2) && (iter == LAST_ITER);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (i_start) state_next = DRIVE;
         DRIVE:   state_next = CHECK;
         CHECK:   state_next = last_vec ? DONE : DRIVE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_add1        <= '0;
         o_add2        <= '0;
         iter          <= '0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_pass        <= 1'b0;
         o_error_cnt   <= '0;
         o_fail_add1   <= '0;
         o_fail_add2   <= '0;
         o_fail_result <= '0;
         fail_seen     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_start) begin
                  o_add1        <= '0;
                  o_add2        <= '0;
                  iter          <= '0;
                  o_busy        <= 1'b1;
                  o_pass        <= 1'b0;
                  o_error_cnt   <= '0;
                  o_fail_add1   <= '0;
                  o_fail_add2   <= '0;
                  o_fail_result <= '0;
                  fail_seen     <= 1'b0;
               end
            end
            CHECK: begin
               o_error_cnt <= cnt_next;
               if (mismatch && !fail_seen) begin
                  o_fail_add1   <= o_add1;
                  o_fail_add2   <= o_add2;
                  o_fail_result <= i_result;
                  fail_seen     <= 1'b1;
               end
               // add2 inner, add1 middle, iteration outer; all wrap to zero
               o_add2 <= o_add2 + WIDTH'(1);
               if (&o_add2) begin
                  o_add1 <= o_add1 + WIDTH'(1);
                  if (&o_add1) begin
                     iter <= (iter == LAST_ITER) ? '0 : iter + ITER_W'(1);
                  end
               end
               if (last_vec) begin
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  o_pass <= (cnt_next == '0);
               end
            end
            DONE: begin
               o_done <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_carry_lookahead_adder_bist.sv
// Bench for carry_lookahead_adder_bist: four instances (clean, injected, stuck-bit, saturating).
`default_nettype none

module tb_carry_lookahead_adder_bist;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic inject = 1'b1;

   logic [2:0]  a1  [4];
   logic [2:0]  a2  [4];
   logic [3:0]  res [4];
   logic        busy[4];
   logic        done[4];
   logic        pass[4];
   logic [15:0] err [4];
   logic [3:0]  err_d;
   logic [2:0]  f1  [4];
   logic [2:0]  f2  [4];
   logic [3:0]  fr  [4];

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // Adder models: 0/1 correct, 2/3 with result bit0 stuck at 0
   assign res[0] = {1'b0, a1[0]} + {1'b0, a2[0]};
   assign res[1] = {1'b0, a1[1]} + {1'b0, a2[1]};
   assign res[2] = ({1'b0, a1[2]} + {1'b0, a2[2]}) & 4'b1110;
   assign res[3] = ({1'b0, a1[3]} + {1'b0, a2[3]}) & 4'b1110;
   assign err[3] = {12'd0, err_d};

   carry_lookahead_adder_bist #(.WIDTH(3), .NUM_ITERATIONS(1), .CNT_W(16)) u_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inject_err(inject),
      .o_add1(a1[0]), .o_add2(a2[0]), .i_result(res[0]),
      .o_busy(busy[0]), .o_done(done[0]), .o_pass(pass[0]), .o_error_cnt(err[0]),
      .o_fail_add1(f1[0]), .o_fail_add2(f2[0]), .o_fail_result(fr[0]));

   carry_lookahead_adder_bist #(.WIDTH(3), .NUM_ITERATIONS(2), .CNT_W(16)) u_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inject_err(inject),
      .o_add1(a1[1]), .o_add2(a2[1]), .i_result(res[1]),
      .o_busy(busy[1]), .o_done(done[1]), .o_pass(pass[1]), .o_error_cnt(err[1]),
      .o_fail_add1(f1[1]), .o_fail_add2(f2[1]), .o_fail_result(fr[1]));

   carry_lookahead_adder_bist #(.WIDTH(3), .NUM_ITERATIONS(1), .CNT_W(16)) u_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inject_err(inject),
      .o_add1(a1[2]), .o_add2(a2[2]), .i_result(res[2]),
      .o_busy(busy[2]), .o_done(done[2]), .o_pass(pass[2]), .o_error_cnt(err[2]),
      .o_fail_add1(f1[2]), .o_fail_add2(f2[2]), .o_fail_result(fr[2]));

   carry_lookahead_adder_bist #(.WIDTH(3), .NUM_ITERATIONS(1), .CNT_W(4)) u_d (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inject_err(inject),
      .o_add1(a1[3]), .o_add2(a2[3]), .i_result(res[3]),
      .o_busy(busy[3]), .o_done(done[3]), .o_pass(pass[3]), .o_error_cnt(err_d),
      .o_fail_add1(f1[3]), .o_fail_add2(f2[3]), .o_fail_result(fr[3]));

   typedef struct {
      string name;
      int    cnt;
      int    fa1;
      int    fa2;
      int    fres;
      int    ok;
   } exp_t;

   exp_t tbl[4];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, req);
      end
   endtask

   task automatic check_reset_all(input string tag);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 0);
         check($sformatf("%s_done%0d", tag, i), 32'(done[i]), 0);
         check($sformatf("%s_pass%0d", tag, i), 32'(pass[i]), 0);
         check($sformatf("%s_ops%0d", tag, i), {26'd0, a1[i], a2[i]}, 0);
         check($sformatf("%s_err%0d", tag, i), 32'(err[i]), 0);
         check($sformatf("%s_fail%0d", tag, i), {22'd0, f1[i], f2[i], fr[i]}, 0);
      end
   endtask

   // One start at E0, a stray start at E0+50, then watch both run lengths
   task automatic run_full(input string tag);
      int na, nb, cnt_a, cnt_b;
      na = 0; nb = 0; cnt_a = 0; cnt_b = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_e0"}, 32'(busy[0]), 1);
      check({tag, "_v0"}, {26'd0, a1[0], a2[0]}, 0);
      for (int n = 1; n <= 270; n++) begin
         @(posedge clk);
         #1;
         if (n == 2)   check({tag, "_v1"}, {26'd0, a1[0], a2[0]}, 32'h01);
         if (n == 16)  check({tag, "_v8"}, {26'd0, a1[0], a2[0]}, 32'h08);
         if (n == 49)  start = 1'b1;
         if (n == 50)  start = 1'b0;
         if (n == 127) check({tag, "_busy_127"}, 32'(busy[0]), 1);
         if (done[0]) begin
            if (na == 0) begin
               na = n;
               check({tag, "_busy_at_done"}, 32'(busy[0]), 0);
            end
            cnt_a++;
         end
         if (done[1]) begin
            if (nb == 0) nb = n;
            cnt_b++;
         end
      end
      check({tag, "_done_a_cycle"}, na, 128);
      check({tag, "_done_a_count"}, cnt_a, 1);
      check({tag, "_done_b_cycle"}, nb, 256);
      check({tag, "_done_b_count"}, cnt_b, 1);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_", tbl[i].name, "_cnt"}, 32'(err[i]), tbl[i].cnt);
         check({tag, "_", tbl[i].name, "_fa1"}, 32'(f1[i]), tbl[i].fa1);
         check({tag, "_", tbl[i].name, "_fa2"}, 32'(f2[i]), tbl[i].fa2);
         check({tag, "_", tbl[i].name, "_fres"}, 32'(fr[i]), tbl[i].fres);
         check({tag, "_", tbl[i].name, "_pass"}, 32'(pass[i]), tbl[i].ok);
      end
   endtask

   initial begin
      int saw_done;
      tbl[0] = '{"clean",  0, 0, 0, 0, 1};
      tbl[1] = '{"inject", 8, 7, 0, 7, 0};
      tbl[2] = '{"stuck", 32, 0, 1, 0, 0};
      tbl[3] = '{"sat",   15, 0, 1, 0, 0};

      #2;
      check_reset_all("rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      run_full("run1");

      // Abort a run at E0+40 with an asynchronous reset
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      check("pre_abort_busy", 32'(busy[2]), 1);
      check("pre_abort_err_nonzero", 32'(err[2] != 0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_all("abort");
      saw_done = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) if (done[i]) saw_done++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (150) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) if (done[i]) saw_done++;
      end
      check("abort_no_done", saw_done, 0);

      run_full("run2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
